// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared definitions for the output-port-lookup pipeline stages.
//   gate_state_e       : packet_drop_gate FSM encoding
//   COUNTER_CLEAR_CODE : register-bus value that zeroes the statistics counters
//   verdict_is_drop    : reduces a header-check drop vector to a drop decision
// ---------------------------------------------------------------------------
package router_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PASS    = 2'd1,
      DISCARD = 2'd2
   } gate_state_e;

   localparam logic [31:0] COUNTER_CLEAR_CODE = 32'd1;

   function automatic logic verdict_is_drop(input logic [4:0] vec);
      return |vec;
   endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// ---------------------------------------------------------------------------
// fallthrough_small_fifo
// First-word-fall-through FIFO: the head entry is visible on dout whenever
// empty is low, and rd_en consumes it.
//   clk, reset   : clock, synchronous active-high reset (pointers/count only)
//   din, wr_en   : write port; writes while full are ignored
//   rd_en        : pop the head entry; ignored while empty
//   dout         : head entry
//   nearly_full  : at most one free slot remains
//   empty        : no entries stored
// ---------------------------------------------------------------------------
module fallthrough_small_fifo #(
   parameter int WIDTH          = 72,
   parameter int MAX_DEPTH_BITS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             nearly_full,
   output logic             empty
);

   localparam int DEPTH = 1 << MAX_DEPTH_BITS;

   logic [WIDTH-1:0]          mem [DEPTH];
   logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [MAX_DEPTH_BITS:0]   count_q, count_d;
   logic                      full;
   logic                      wr_ok;
   logic                      rd_ok;

   always_comb begin
      full        = (count_q == (MAX_DEPTH_BITS + 1)'(DEPTH));
      empty       = (count_q == '0);
      // One slot of slack so a writer that samples this flag a cycle late
      // can never overrun the storage.
      nearly_full = (count_q >= (MAX_DEPTH_BITS + 1)'(DEPTH - 1));
      dout        = mem[rd_ptr_q];
      wr_ok       = wr_en && !full;
      rd_ok       = rd_en && !empty;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + MAX_DEPTH_BITS'(1);
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + MAX_DEPTH_BITS'(1);
      end
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + (MAX_DEPTH_BITS + 1)'(1);
         2'b01:   count_d = count_q - (MAX_DEPTH_BITS + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries data only, so it is not reset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/packet_drop_gate.sv
// ---------------------------------------------------------------------------
// packet_drop_gate
// Buffers AXI-Stream packets from the header-check stage and applies the
// per-packet drop verdict: packets with a non-zero verdict are discarded
// whole, all others are forwarded bit-exact. Forwarded and discarded packets
// are counted for the register interface.
//   AXI_ACLK, AXI_RESET : clock, synchronous active-high reset
//   S_AXIS_*            : packet input from the header-check stage
//   M_AXIS_*            : packet output toward the output queues
//   drop_valid/vector   : one verdict pulse per packet, in packet order
//   clear_counters      : writing COUNTER_CLEAR_CODE zeroes both counters
//   pass_count          : packets forwarded
//   drop_count          : packets discarded
//   verdict_overflow    : sticky, a verdict arrived while the queue was full
// ---------------------------------------------------------------------------
module packet_drop_gate
   import router_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH     = 256,
   parameter int C_S_AXIS_DATA_WIDTH     = 256,
   parameter int C_M_AXIS_TUSER_WIDTH    = 128,
   parameter int C_S_AXIS_TUSER_WIDTH    = 128,
   parameter int C_S_AXI_DATA_WIDTH      = 32,
   parameter int DATA_FIFO_DEPTH_BITS    = 4,
   parameter int VERDICT_FIFO_DEPTH_BITS = 4
) (
   input  logic                                AXI_ACLK,
   input  logic                                AXI_RESET,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
   input  logic                                S_AXIS_TVALID,
   output logic                                S_AXIS_TREADY,
   input  logic                                S_AXIS_TLAST,

   output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
   output logic                                M_AXIS_TVALID,
   input  logic                                M_AXIS_TREADY,
   output logic                                M_AXIS_TLAST,

   input  logic                                drop_valid,
   input  logic [4:0]                          drop_vector,

   input  logic [C_S_AXI_DATA_WIDTH-1:0]       clear_counters,
   output logic [C_S_AXI_DATA_WIDTH-1:0]       pass_count,
   output logic [C_S_AXI_DATA_WIDTH-1:0]       drop_count,
   output logic                                verdict_overflow
);

   if (C_S_AXIS_DATA_WIDTH != C_M_AXIS_DATA_WIDTH) begin : g_chk_data_w
      $error("packet_drop_gate: slave and master tdata widths differ");
   end
   if (C_S_AXIS_TUSER_WIDTH != C_M_AXIS_TUSER_WIDTH) begin : g_chk_user_w
      $error("packet_drop_gate: slave and master tuser widths differ");
   end
   if (VERDICT_FIFO_DEPTH_BITS < DATA_FIFO_DEPTH_BITS) begin : g_chk_depth
      $error("packet_drop_gate: verdict queue shallower than data FIFO");
   end

   localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;
   localparam int FIFO_W = 1 + C_S_AXIS_TUSER_WIDTH + STRB_W + C_S_AXIS_DATA_WIDTH;
   localparam int VB     = VERDICT_FIFO_DEPTH_BITS;
   localparam int VDEPTH = 1 << VB;
   localparam int CW     = C_S_AXI_DATA_WIDTH;

   // ---------------- data FIFO ----------------
   logic [FIFO_W-1:0] fifo_din;
   logic [FIFO_W-1:0] fifo_dout;
   logic              fifo_wr;
   logic              fifo_rd;
   logic              fifo_nearly_full;
   logic              data_empty;
   logic              head_last;

   always_comb begin
      fifo_din      = {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
      S_AXIS_TREADY = !fifo_nearly_full;
      fifo_wr       = S_AXIS_TVALID && !fifo_nearly_full;
   end

   fallthrough_small_fifo #(
      .WIDTH          (FIFO_W),
      .MAX_DEPTH_BITS (DATA_FIFO_DEPTH_BITS)
   ) data_fifo (
      .clk         (AXI_ACLK),
      .reset       (AXI_RESET),
      .din         (fifo_din),
      .wr_en       (fifo_wr),
      .rd_en       (fifo_rd),
      .dout        (fifo_dout),
      .nearly_full (fifo_nearly_full),
      .empty       (data_empty)
   );

   always_comb begin
      {head_last, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TDATA} = fifo_dout;
      M_AXIS_TLAST = head_last;
   end

   // ---------------- verdict queue ----------------
   logic [VDEPTH-1:0] v_mem_q, v_mem_d;
   logic [VB-1:0]     v_wr_ptr_q, v_wr_ptr_d;
   logic [VB-1:0]     v_rd_ptr_q, v_rd_ptr_d;
   logic [VB:0]       v_occ_q, v_occ_d;
   logic              overflow_q, overflow_d;
   logic              v_full;
   logic              v_empty;
   logic              v_head;
   logic              v_push;
   logic              v_pop;

   always_comb begin
      v_full  = (v_occ_q == (VB + 1)'(VDEPTH));
      v_empty = (v_occ_q == '0);
      v_head  = v_mem_q[v_rd_ptr_q];
      // A pulse arriving while full is lost even if a pop happens in the
      // same cycle; the sticky flag records that the upstream contract broke.
      v_push  = drop_valid && !v_full;
   end

   always_comb begin
      v_mem_d    = v_mem_q;
      v_wr_ptr_d = v_wr_ptr_q;
      v_rd_ptr_d = v_rd_ptr_q;
      v_occ_d    = v_occ_q;
      overflow_d = overflow_q || (drop_valid && v_full);
      if (v_push) begin
         v_mem_d[v_wr_ptr_q] = verdict_is_drop(drop_vector);
         v_wr_ptr_d          = v_wr_ptr_q + VB'(1);
      end
      if (v_pop) begin
         v_rd_ptr_d = v_rd_ptr_q + VB'(1);
      end
      case ({v_push, v_pop})
         2'b10:   v_occ_d = v_occ_q + (VB + 1)'(1);
         2'b01:   v_occ_d = v_occ_q - (VB + 1)'(1);
         default: v_occ_d = v_occ_q;
      endcase
   end

   // ---------------- packet FSM ----------------
   gate_state_e state_q, state_d;
   logic        pass_inc;
   logic        drop_inc;

   always_comb begin
      state_d       = state_q;
      v_pop         = 1'b0;
      fifo_rd       = 1'b0;
      M_AXIS_TVALID = 1'b0;
      pass_inc      = 1'b0;
      drop_inc      = 1'b0;
      case (state_q)
         IDLE: begin
            // Commit to a packet only once both its first beat and its
            // verdict are buffered, so nothing leaks out before the decision.
            if (!data_empty && !v_empty) begin
               v_pop   = 1'b1;
               state_d = v_head ? DISCARD : PASS;
            end
         end
         PASS: begin
            M_AXIS_TVALID = !data_empty;
            if (!data_empty && M_AXIS_TREADY) begin
               fifo_rd = 1'b1;
               if (head_last) begin
                  state_d  = IDLE;
                  pass_inc = 1'b1;
               end
            end
         end
         DISCARD: begin
            // Dropped beats drain at full rate regardless of downstream.
            if (!data_empty) begin
               fifo_rd = 1'b1;
               if (head_last) begin
                  state_d  = IDLE;
                  drop_inc = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- statistics ----------------
   logic [CW-1:0] pass_count_q, pass_count_d;
   logic [CW-1:0] drop_count_q, drop_count_d;
   logic          clear_hit;

   always_comb begin
      clear_hit    = (clear_counters == CW'(COUNTER_CLEAR_CODE));
      pass_count_d = pass_count_q;
      drop_count_d = drop_count_q;
      // Clear outranks a coincident increment; increments wrap naturally.
      if (clear_hit) begin
         pass_count_d = '0;
         drop_count_d = '0;
      end else begin
         if (pass_inc) begin
            pass_count_d = pass_count_q + CW'(1);
         end
         if (drop_inc) begin
            drop_count_d = drop_count_q + CW'(1);
         end
      end
      pass_count       = pass_count_q;
      drop_count       = drop_count_q;
      verdict_overflow = overflow_q;
   end

   always_ff @(posedge AXI_ACLK) begin
      if (AXI_RESET) begin
         state_q      <= IDLE;
         v_wr_ptr_q   <= '0;
         v_rd_ptr_q   <= '0;
         v_occ_q      <= '0;
         overflow_q   <= 1'b0;
         pass_count_q <= '0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         v_wr_ptr_q   <= v_wr_ptr_d;
         v_rd_ptr_q   <= v_rd_ptr_d;
         v_occ_q      <= v_occ_d;
         overflow_q   <= overflow_d;
         pass_count_q <= pass_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   // Verdict storage is qualified by the occupancy counter, so it is not reset.
   always_ff @(posedge AXI_ACLK) begin
      v_mem_q <= v_mem_d;
   end

endmodule

// File: tb/tb_packet_drop_gate.sv
module tb_packet_drop_gate;

   typedef struct packed {
      logic         l;
      logic [127:0] u;
      logic [31:0]  s;
      logic [255:0] d;
   } beat_t;

   logic         clk;
   logic         rst;
   logic [255:0] s_tdata;
   logic [31:0]  s_tstrb;
   logic [127:0] s_tuser;
   logic         s_tvalid;
   logic         s_tready;
   logic         s_tlast;
   logic [255:0] m_tdata;
   logic [31:0]  m_tstrb;
   logic [127:0] m_tuser;
   logic         m_tvalid;
   logic         m_tready;
   logic         m_tlast;
   logic         drop_valid;
   logic [4:0]   drop_vector;
   logic [31:0]  clear_counters;
   logic [31:0]  pass_count;
   logic [31:0]  drop_count;
   logic         verdict_overflow;

   beat_t exp_q[$];
   int    checks   = 0;
   int    errors   = 0;
   int    accepted = 0;

   packet_drop_gate dut (
      .AXI_ACLK         (clk),
      .AXI_RESET        (rst),
      .S_AXIS_TDATA     (s_tdata),
      .S_AXIS_TSTRB     (s_tstrb),
      .S_AXIS_TUSER     (s_tuser),
      .S_AXIS_TVALID    (s_tvalid),
      .S_AXIS_TREADY    (s_tready),
      .S_AXIS_TLAST     (s_tlast),
      .M_AXIS_TDATA     (m_tdata),
      .M_AXIS_TSTRB     (m_tstrb),
      .M_AXIS_TUSER     (m_tuser),
      .M_AXIS_TVALID    (m_tvalid),
      .M_AXIS_TREADY    (m_tready),
      .M_AXIS_TLAST     (m_tlast),
      .drop_valid       (drop_valid),
      .drop_vector      (drop_vector),
      .clear_counters   (clear_counters),
      .pass_count       (pass_count),
      .drop_count       (drop_count),
      .verdict_overflow (verdict_overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_beat(input string name, input beat_t act, input beat_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic beat_t mk_beat(input int pid, input int b, input int nb);
      beat_t       x;
      logic [31:0] w;
      w   = {8'hA5, 8'(pid), 8'(b), 8'(nb)};
      x.d = {w, ~w, w ^ 32'h5A5A_5A5A, w + 32'd1, w, ~w, w ^ 32'hC3C3_C3C3, w + 32'd9};
      x.u = {w ^ 32'h1234_5678, ~w, w, w + 32'd7};
      x.s = (b == nb - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      x.l = (b == nb - 1);
      return x;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends one packet; the verdict pulses alongside beat vbeat (-1: none).
   task automatic send_pkt(input int pid, input int nb, input logic [4:0] vv,
                           input int vbeat, input logic exp_pass);
      beat_t bt;
      int    guard;
      logic  took;
      for (int b = 0; b < nb; b++) begin
         bt = mk_beat(pid, b, nb);
         if (exp_pass) exp_q.push_back(bt);
         s_tdata  = bt.d;
         s_tstrb  = bt.s;
         s_tuser  = bt.u;
         s_tlast  = bt.l;
         s_tvalid = 1'b1;
         if (b == vbeat) begin
            drop_valid  = 1'b1;
            drop_vector = vv;
         end
         took  = 1'b0;
         guard = 0;
         while (!took && guard < 100) begin
            @(negedge clk);
            took = s_tready;
            @(posedge clk);
            #1;
            drop_valid = 1'b0;
            guard++;
         end
         if (!took) begin
            checks++;
            errors++;
            $display("FAIL s_accept_timeout: pkt %0d beat %0d not accepted", pid, b);
         end
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_verdict(input logic [4:0] vv);
      drop_valid  = 1'b1;
      drop_vector = vv;
      tick();
      drop_valid  = 1'b0;
   endtask

   task automatic drain(input int settle);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         tick();
         n++;
      end
      chk("drain_pending_beats", 32'(exp_q.size()), 32'd0);
      repeat (settle) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      exp_q.delete();
      rst = 1'b0;
   endtask

   // Scoreboard monitor: pops and compares on every output handshake.
   initial begin
      beat_t got;
      beat_t exp_b;
      beat_t stall_b;
      logic  stalled;
      logic  gap_pend;
      stalled  = 1'b0;
      gap_pend = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled  = 1'b0;
            gap_pend = 1'b0;
         end else begin
            got = {m_tlast, m_tuser, m_tstrb, m_tdata};
            if (gap_pend) begin
               chk("idle_gap_after_last", 32'(m_tvalid), 32'd0);
               gap_pend = 1'b0;
            end
            if (stalled) begin
               chk("stall_valid_held", 32'(m_tvalid), 32'd1);
               chk_beat("stall_data_held", got, stall_b);
            end
            stalled = m_tvalid && !m_tready;
            stall_b = got;
            if (m_tvalid && m_tready) begin
               accepted++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got %h expected none", got);
               end else begin
                  exp_b = exp_q.pop_front();
                  chk_beat("out_beat", got, exp_b);
               end
               if (got.l) gap_pend = 1'b1;
            end
         end
      end
   end

   initial begin
      int acc0;
      int g;
      logic [4:0] pat [17];

      rst            = 1'b1;
      s_tdata        = '0;
      s_tstrb        = '0;
      s_tuser        = '0;
      s_tvalid       = 1'b0;
      s_tlast        = 1'b0;
      m_tready       = 1'b1;
      drop_valid     = 1'b0;
      drop_vector    = '0;
      clear_counters = '0;

      // Reset state
      do_reset();
      @(negedge clk);
      chk("rst_s_tready", 32'(s_tready), 32'd1);
      chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_pass_count", pass_count, 32'd0);
      chk("rst_drop_count", drop_count, 32'd0);
      chk("rst_overflow", 32'(verdict_overflow), 32'd0);
      tick();

      // Three 4-beat passing packets, continuous TREADY
      send_pkt(1, 4, 5'd0, 0, 1'b1);
      send_pkt(2, 4, 5'd0, 0, 1'b1);
      send_pkt(3, 4, 5'd0, 0, 1'b1);
      drain(3);
      chk("t1_pass_count", pass_count, 32'd3);
      chk("t1_drop_count", drop_count, 32'd0);

      // Clear, then A pass / B drop / C pass; B drains while TREADY is low
      clear_counters = 32'd1;
      tick();
      clear_counters = 32'd0;
      @(negedge clk);
      chk("clear_pass_count", pass_count, 32'd0);
      tick();
      acc0 = accepted;
      fork
         begin
            send_pkt(10, 4, 5'd0, 1, 1'b1);
            send_pkt(11, 4, 5'b00010, 1, 1'b0);
            send_pkt(12, 4, 5'd0, 1, 1'b1);
         end
         begin
            g = 0;
            while (accepted < acc0 + 4 && g < 200) begin
               @(negedge clk);
               g++;
            end
            @(posedge clk);
            #1;
            m_tready = 1'b0;
            g = 0;
            while (drop_count != 32'd1 && g < 100) begin
               @(negedge clk);
               g++;
            end
            chk("t2_drop_while_stalled", drop_count, 32'd1);
            chk("t2_pass_while_stalled", pass_count, 32'd1);
         end
      join
      m_tready = 1'b1;
      drain(3);
      chk("t2_pass_count", pass_count, 32'd2);
      chk("t2_drop_count", drop_count, 32'd1);

      // Verdict arrives six cycles after the first beat
      send_pkt(30, 4, 5'd0, -1, 1'b1);
      repeat (2) begin
         @(negedge clk);
         chk("t3_no_valid_before_verdict", 32'(m_tvalid), 32'd0);
         tick();
      end
      drop_valid  = 1'b1;
      drop_vector = 5'd0;
      @(negedge clk);
      chk("t3_no_valid_in_verdict_cycle", 32'(m_tvalid), 32'd0);
      tick();
      drop_valid = 1'b0;
      g = 0;
      while (!m_tvalid && g < 4) begin
         @(negedge clk);
         g++;
      end
      chk("t3_valid_after_verdict", 32'(m_tvalid), 32'd1);
      drain(3);
      chk("t3_pass_count", pass_count, 32'd3);

      // TREADY 1,0,0,1 during a forwarded packet
      acc0 = accepted;
      fork
         send_pkt(40, 4, 5'd0, 0, 1'b1);
         begin
            g = 0;
            while (!m_tvalid && g < 50) begin
               @(negedge clk);
               g++;
            end
            @(posedge clk);
            #1;
            m_tready = 1'b0;
            tick();
            tick();
            m_tready = 1'b1;
         end
      join
      drain(3);
      chk("t4_beats_out", 32'(accepted - acc0), 32'd4);
      chk("t4_pass_count", pass_count, 32'd4);

      // Verdict queue overflow
      do_reset();
      for (int i = 0; i < 17; i++) pat[i] = (i % 3 == 0) ? 5'b10000 : 5'b00000;
      pat[16] = 5'b00100;
      for (int i = 0; i < 16; i++) send_verdict(pat[i]);
      @(negedge clk);
      chk("t5_no_overflow_at_16", 32'(verdict_overflow), 32'd0);
      tick();
      send_verdict(pat[16]);
      @(negedge clk);
      chk("t5_overflow_set", 32'(verdict_overflow), 32'd1);
      tick();
      for (int i = 0; i < 16; i++) send_pkt(50 + i, 1, 5'd0, -1, (pat[i] == 5'd0));
      drain(20);
      chk("t5_pass_count", pass_count, 32'd10);
      chk("t5_drop_count", drop_count, 32'd6);
      send_pkt(99, 1, 5'd0, -1, 1'b0);
      repeat (10) tick();
      @(negedge clk);
      chk("t5_no_17th_verdict_valid", 32'(m_tvalid), 32'd0);
      chk("t5_drop_count_after_extra", drop_count, 32'd6);
      chk("t5_overflow_sticky", 32'(verdict_overflow), 32'd1);
      do_reset();
      @(negedge clk);
      chk("t5_overflow_cleared_by_reset", 32'(verdict_overflow), 32'd0);
      chk("t5_rst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("t5_rst_pass_count", pass_count, 32'd0);
      tick();

      // Counter wrap
      force dut.pass_count_q = 32'hFFFF_FFFF;
      tick();
      tick();
      release dut.pass_count_q;
      @(negedge clk);
      chk("t6_preload", pass_count, 32'hFFFF_FFFF);
      tick();
      send_pkt(200, 2, 5'd0, 0, 1'b1);
      drain(3);
      chk("t6_wrap_to_zero", pass_count, 32'd0);

      // Clear versus increment, and a non-matching clear value
      send_pkt(201, 1, 5'd0, 0, 1'b1);
      drain(3);
      chk("t6_pass_one", pass_count, 32'd1);
      clear_counters = 32'd3;
      tick();
      @(negedge clk);
      chk("t6_clear_code_3_ignored", pass_count, 32'd1);
      tick();
      clear_counters = 32'd1;
      send_pkt(202, 2, 5'd0, 0, 1'b1);
      drain(3);
      chk("t6_clear_beats_increment", pass_count, 32'd0);
      clear_counters = 32'd0;
      tick();
      @(negedge clk);
      chk("t6_pass_after_clear", pass_count, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/packet_drop_gate.md
# packet_drop_gate

Stream stage that sits directly downstream of the header-check stage in the router output-port-lookup pipeline. It buffers AXI-Stream packets and consumes the per-packet drop verdict that the header-check stage produces one cycle after each header beat. Packets with a non-zero verdict are discarded whole. All other packets are forwarded unchanged. Forwarded and discarded packets are counted for the register interface.

## Interface
Parameters
- C_M_AXIS_DATA_WIDTH, 256, master tdata width
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width; must equal master width
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; must equal master width
- C_S_AXI_DATA_WIDTH, 32, register-bus width
- DATA_FIFO_DEPTH_BITS, 4, log2 depth of the packet-beat FIFO
- VERDICT_FIFO_DEPTH_BITS, 4, log2 depth of the verdict queue; must be ≥ DATA_FIFO_DEPTH_BITS

Ports
- AXI_ACLK  in  1  single clock
- AXI_RESET  in  1  reset; synchronous, active-high
- S_AXIS_TDATA / TSTRB / TUSER / TVALID / TREADY / TLAST  in/in/in/in/out/in  256/32/128/1/1/1  packet input from the header-check stage
- M_AXIS_TDATA / TSTRB / TUSER / TVALID / TREADY / TLAST  out/out/out/out/in/out  256/32/128/1/1/1  packet output toward the output queues
- drop_valid  in  1  one-cycle pulse; one pulse per packet, in packet order
- drop_vector  in  5  verdict for that packet; drop = |drop_vector
- clear_counters  in  32  counter clear; clear is active when the value equals 32'd1
- pass_count  out  32  number of packets forwarded
- drop_count  out  32  number of packets discarded
- verdict_overflow  out  1  sticky flag; set when a verdict arrives while the verdict queue is full

## Operation
- Data FIFO: fall-through FIFO holding {TLAST, TUSER, TSTRB, TDATA}.
  - Write on S_AXIS_TVALID & S_AXIS_TREADY.
  - S_AXIS_TREADY = !nearly_full.
- Verdict queue: 1-bit FIFO holding |drop_vector.
  - Push on drop_valid.
  - A push while full is dropped and sets verdict_overflow. The flag clears only on reset.
- Upstream contract: exactly one verdict per packet, including single-beat packets. A verdict may arrive before, with, or after any beat of its packet.
- FSM states IDLE, PASS, DISCARD; the state register resets to IDLE.
  - IDLE → PASS when the data FIFO is non-empty, the verdict queue is non-empty, and the head verdict = 0. The verdict is popped on this transition.
  - IDLE → DISCARD under the same conditions with the head verdict = 1. The verdict is popped on this transition.
  - PASS: M_AXIS_TVALID = !data_empty. A beat pops on M_AXIS_TVALID & M_AXIS_TREADY. A popped beat with TLAST = 1 → IDLE and pass_count +1.
  - DISCARD: M_AXIS_TVALID = 0. One beat pops every cycle the FIFO is non-empty, independent of M_AXIS_TREADY. A popped beat with TLAST = 1 → IDLE and drop_count +1.
  - M_AXIS_TVALID = 0 in IDLE.
- Waiting cases:
  - Data present but no verdict: stay in IDLE; no beat is emitted.
  - Verdict present but no data: stay in IDLE.
- Counters: 32-bit, wrap from 2^32−1 to 0. A clear_counters value of 32'd1 zeroes both counters; clear wins over a simultaneous increment.
- M_AXIS_TDATA, TSTRB, TUSER and TLAST are driven directly from the FIFO head and are bit-exact to the input.

## Timing
- Reset (AXI_RESET = 1 at a clock edge):
  - state = IDLE; both FIFOs emptied.
  - M_AXIS_TVALID = 0, pass_count = 0, drop_count = 0, verdict_overflow = 0.
  - S_AXIS_TREADY = 1 in the cycle after reset.
- Reset in the middle of a packet discards everything buffered. There is no partial-packet recovery; upstream is reset by the same signal.
- Latency, PASS: when the first beat and its verdict are both present at edge N, the state becomes PASS at N+1 and M_AXIS_TVALID is high in the N+1 cycle.
- Throughput:
  - PASS: one beat per cycle under continuous TREADY.
  - DISCARD: one beat per cycle regardless of TREADY.
- One IDLE cycle separates consecutive packets.
- M_AXIS_TVALID may fall only after a handshake or at the end of a packet. Data is held stable while TVALID = 1 and TREADY = 0.
- drop_valid in the same cycle as a verdict pop: both take effect; the queue occupancy is unchanged.

## Structure
- Shared package router_pkg:
  - FSM state encoding (IDLE = 2'd0, PASS = 2'd1, DISCARD = 2'd2).
  - COUNTER_CLEAR_CODE = 32'd1.
- Data FIFO: the existing fallthrough_small_fifo sub-module, instance data_fifo.
- Verdict queue: inline, using read/write pointers plus an occupancy counter.

## Test plan
- Three 4-beat packets with verdicts 0, 0, 0 and TREADY held high → 12 beats out, bit-exact; pass_count = 3; one IDLE gap between packets.
- Packets A, B, C with verdicts 0, 5'b00010, 0 → only A and C appear at the output; pass_count = 2, drop_count = 1; B is consumed while TREADY = 0.
- Verdict arrives 6 cycles after the first beat of its packet → no M_AXIS_TVALID until 1 cycle after the verdict.
- TREADY toggled 1,0,0,1 during a PASS packet → TDATA held stable while stalled; no beat lost or duplicated.
- 17 verdict pulses with no data → verdict_overflow = 1, the queue holds the first 16 verdicts, and the flag remains set until reset.
- pass_count = 32'hFFFFFFFF, then one packet forwarded → pass_count = 0. clear_counters = 32'd1 in the same cycle as an increment → pass_count = 0.
